divider64b_seq: RTL and testbench
=================================

# divider64b_seq

Iterative 64-bit signed/unsigned integer divider for the ALU's M-extension path. It computes quotient and remainder one bit per cycle (restoring algorithm), using the existing 64-bit add/subtract block for the trial subtraction. It sits beside the adder in the ALU and is driven by a start/done handshake from the execute stage. Divide-by-zero and signed-overflow results follow RISC-V semantics.

## Interface
- `WIDTH`, 64, operand and result width; the iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `is_signed`  in  1  1 = DIV/REM semantics, 0 = DIVU/REMU; sampled with `start`
- `A`  in  WIDTH  dividend; sampled with `start`
- `B`  in  WIDTH  divisor; sampled with `start`
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle pulse; `Q`/`R` are valid from this cycle on
- `Q`  out  WIDTH  quotient; held until the next accepted `start`
- `R`  out  WIDTH  remainder; held until the next accepted `start`

## Operation
- States:
  - IDLE
  - CALC: WIDTH cycles
  - FIX: sign correction
  - DONE: one cycle
- **IDLE, `start`=1:**
  - Latch `is_signed`.
  - Latch |A| and |B| (absolute values when signed, raw values otherwise).
  - Latch sign_q = A[63]^B[63] and sign_r = A[63], both gated by `is_signed`.
  - Clear the partial remainder and the counter.
  - Go to CALC, except for the special cases below.
- **Special cases** (go IDLE→DONE directly):
  - B=0: Q = all ones, R = A.
  - Signed, A=0x8000_0000_0000_0000, B=-1: Q = A, R = 0.
- **CALC, each cycle:**
  - Shift {rem, dividend} left by 1.
  - Compute trial = rem_shifted − |B| using the adder with SUB=1.
  - If COUT=1 (no borrow), set rem = trial and the quotient LSB = 1. Otherwise keep rem and set the LSB to 0.
  - Counter increments; after WIDTH iterations, go to FIX.
- **FIX:**
  - Q = sign_q ? −q : q.
  - R = sign_r ? −r : r.
  - The remainder takes the dividend's sign.
  - Go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored; there is no queueing.
- A new `start` in the cycle right after DONE (back in IDLE) is accepted normally.
- All arithmetic is modulo 2^WIDTH. Negation is two's complement.

## Timing
- **Reset:** `rst_n` low forces IDLE asynchronously. `busy`=0, `done`=0, `Q`=0, `R`=0, and the counter is 0.
- **Reset mid-CALC:** the operation is abandoned and no `done` is produced.
- **Normal latency:**
  - `start` is sampled at edge E0.
  - CALC occupies E1..E64 and FIX is at E65.
  - `done` is high in the cycle after E66, i.e. 66 clocks from `start` to `done`.
- **Special-case latency:** `done` is high in the cycle after E1 (1 clock).
- **Outputs:**
  - `busy` is high from E0 until the edge that asserts `done`.
  - `busy` and `done` are never both high.
  - `Q`/`R` change only at FIX, or at the IDLE→DONE transition for special cases.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Shared ALU package** (`alu_pkg`): state encoding (IDLE, CALC, FIX, DONE), `WIDTH` default, the special-case constants `MOST_NEG` = 1<<63 and `ALL_ONES`.
- **Sub-module:** one instance of `Adder64b_mod` (A = shifted remainder, B = |B|, SUB=1) for the trial subtraction. Its COUT is the no-borrow flag.
- Negation for abs/fix-up is done with local `~x+1`; no second adder instance.
- Counter width is $clog2(WIDTH)+1.

## Test plan
- Unsigned 100 / 7 -> after 66 cycles `done`=1, Q=14, R=2; `busy` high for exactly 66 cycles.
- Signed −110 / 33 -> Q=−3, R=−11; signed 53 / −47 -> Q=−1, R=6.
- B=0 with A=5 (signed and unsigned) -> `done` the next cycle, Q=0xFFFF_FFFF_FFFF_FFFF, R=5.
- Signed 0x8000_0000_0000_0000 / −1 -> 1-cycle `done`, Q=0x8000_0000_0000_0000, R=0. Unsigned same operands -> 66 cycles, Q=0, R=0x8000_0000_0000_0000.
- `start` pulsed at cycle 10 of an active CALC -> ignored; the first result is unchanged and exactly one `done` pulse occurs.
- `rst_n` low at cycle 30 of CALC -> all outputs 0 immediately, no `done`. A fresh 5/4 unsigned afterwards gives Q=1, R=1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : shared ALU definitions (divider state encoding and constants)
// Rev 1.0
// ============================================================================
package alu_pkg;

    localparam int DIV_WIDTH = 64;

    localparam logic [DIV_WIDTH-1:0] MOST_NEG = {1'b1, {(DIV_WIDTH-1){1'b0}}};
    localparam logic [DIV_WIDTH-1:0] ALL_ONES = {DIV_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/Adder64b_mod.sv
`default_nettype none
// ============================================================================
// Adder64b_mod : ALU add/subtract block; COUT is the no-borrow flag on SUB
// Rev 1.0
// ============================================================================
module Adder64b_mod #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    output logic [WIDTH-1:0] S,
    output logic             COUT
);

    logic [WIDTH-1:0] w_b_inv;
    logic [WIDTH:0]   w_sum;

    assign w_b_inv = B ^ {WIDTH{SUB}};
    assign w_sum   = {1'b0, A} + {1'b0, w_b_inv} + {{WIDTH{1'b0}}, SUB};
    assign S       = w_sum[WIDTH-1:0];
    assign COUT    = w_sum[WIDTH];

endmodule
`default_nettype wire

// File: rtl/divider64b_seq.sv
`default_nettype none
// ============================================================================
// divider64b_seq : iterative restoring divider, one quotient bit per cycle,
//                  RISC-V DIV/DIVU/REM/REMU semantics
// Rev 1.0
// ============================================================================
module divider64b_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R
);

    localparam int                 c_CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [WIDTH-1:0]   c_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0]   c_MOST_NEG = WIDTH'(MOST_NEG >> (DIV_WIDTH - WIDTH));
    localparam logic [WIDTH-1:0]   c_ALL_ONES = WIDTH'(ALL_ONES);

    div_state_t         state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;

    logic               w_div0;
    logic               w_ovf;
    logic               w_special;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH-1:0]   w_rem_sh;
    logic [WIDTH-1:0]   w_trial;
    logic               w_cout;
    logic               w_fits;

    assign w_div0    = (B == '0);
    assign w_ovf     = is_signed && (A == c_MOST_NEG) && (B == c_ALL_ONES);
    assign w_special = w_div0 || w_ovf;
    assign w_a_abs   = (is_signed && A[WIDTH-1]) ? (~A + c_ONE) : A;
    assign w_b_abs   = (is_signed && B[WIDTH-1]) ? (~B + c_ONE) : B;

    assign w_rem_sh = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};

    Adder64b_mod #(
        .WIDTH (WIDTH)
    ) u_adder (
        .A    (w_rem_sh),
        .B    (dvs_q),
        .SUB  (1'b1),
        .S    (w_trial),
        .COUT (w_cout)
    );

    // The bit shifted out of rem is the 65th bit of the shifted remainder;
    // when set, the shifted value certainly exceeds the divisor.
    assign w_fits = w_cout | rem_q[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = w_special ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == c_LAST) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            S_IDLE:  busy_d = start;
            S_CALC:  busy_d = 1'b1;
            S_FIX:   busy_d = 1'b1;
            S_DONE:  done_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    always_comb begin
        q_d       = q_q;
        r_d       = r_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d     = w_a_abs;
                    dvs_d     = w_b_abs;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    neg_rem_d = is_signed & A[WIDTH-1];
                    if (w_div0) begin
                        q_d = c_ALL_ONES;
                        r_d = A;
                    end else if (w_ovf) begin
                        q_d = A;
                        r_d = '0;
                    end
                end
            end
            S_CALC: begin
                rem_d = w_fits ? w_trial : w_rem_sh;
                dvd_d = {dvd_q[WIDTH-2:0], w_fits};
                cnt_d = cnt_q + c_CNT_ONE;
            end
            S_FIX: begin
                q_d = neg_quo_q ? (~dvd_q + c_ONE) : dvd_q;
                r_d = neg_rem_q ? (~rem_q + c_ONE) : rem_q;
            end
            default: begin
                q_d = q_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            q_q       <= q_d;
            r_q       <= r_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;

endmodule
`default_nettype wire

// File: tb/tb_divider64b_seq.sv
`default_nettype none
// ============================================================================
// tb_divider64b_seq : scoreboard bench for divider64b_seq against an arithmetic model
// Rev 1.0
// ============================================================================
module tb_divider64b_seq;

    localparam logic [63:0] c_MN   = 64'h8000_0000_0000_0000;
    localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
        int          t0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic        busy;
    logic        done;
    logic [63:0] Q;
    logic [63:0] R;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   busy_run = 0;
    exp_t exp_q[$];
    logic [63:0] last_q = '0;
    logic [63:0] last_r = '0;

    divider64b_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .Q         (Q),
        .R         (R)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void ref_div(input logic [63:0] a, input logic [63:0] b, input logic s,
                                    output logic [63:0] q, output logic [63:0] r, output int lat);
        if (b == 64'd0) begin
            q = c_ONES; r = a; lat = 1;
        end else if (s && a == c_MN && b == c_ONES) begin
            q = a; r = 64'd0; lat = 1;
        end else begin
            lat = 66;
            if (s) begin
                q = 64'($signed(a) / $signed(b));
                r = 64'($signed(a) % $signed(b));
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    // Called at a falling edge; start is sampled at the next rising edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s);
        exp_t e;
        ref_div(a, b, s, e.q, e.r, e.lat);
        e.t0 = cyc + 1;
        exp_q.push_back(e);
        A = a; B = b; is_signed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin seen = 1; break; end
            @(negedge clk);
        end
        if (!seen) begin
            n_err++;
            $display("FAIL done_timeout: no done within 200 cycles, pending=%0d", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || Q !== 64'd0 || R !== 64'd0) begin
            n_err++;
            $display("FAIL %s: busy=%b done=%b Q=%h R=%h, required all zero", tag, busy, done, Q, R);
        end
    endtask

    // Monitor: compares every done pulse against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_run = 0;
            end else begin
                if (busy && done) begin
                    n_err++;
                    $display("FAIL busy_done_overlap at cycle %0d", cyc);
                end
                if (busy) busy_run++;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_done at cycle %0d: Q=%h R=%h", cyc, Q, R);
                    end else begin
                        e = exp_q.pop_front();
                        n_vec++;
                        if (Q !== e.q || R !== e.r || (cyc - e.t0) != e.lat || busy_run != e.lat) begin
                            n_err++;
                            $display("FAIL result: Q=%h R=%h lat=%0d busy=%0d, required Q=%h R=%h lat=%0d busy=%0d",
                                     Q, R, cyc - e.t0, busy_run, e.q, e.r, e.lat, e.lat);
                        end
                        last_q = e.q;
                        last_r = e.r;
                    end
                    busy_run = 0;
                end
            end
        end
    end

    initial begin
        logic [63:0] a, b;
        logic        s;
        int          mode;

        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        issue(64'd100, 64'd7, 1'b0);                       wait_done();
        issue(-64'sd110, 64'd33, 1'b1);                    wait_done();
        issue(64'd53, -64'sd47, 1'b1);                     wait_done();
        issue(64'd5, 64'd0, 1'b1);                         wait_done();
        issue(64'd5, 64'd0, 1'b0);                         wait_done();
        issue(c_MN, c_ONES, 1'b1);                         wait_done();
        issue(c_MN, c_ONES, 1'b0);                         wait_done();
        issue(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0); wait_done();
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0); wait_done();

        // start during CALC must be ignored
        issue(64'd1000, 64'd9, 1'b0);
        repeat (9) @(negedge clk);
        A = 64'd77; B = 64'd3; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (80) @(negedge clk);
        n_vec++;
        if (Q !== last_q || R !== last_r) begin
            n_err++;
            $display("FAIL hold: Q=%h R=%h, required Q=%h R=%h", Q, R, last_q, last_r);
        end

        // reset in the middle of CALC abandons the operation
        issue(64'd123456789, 64'd11, 1'b0);
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_calc");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        issue(64'd5, 64'd4, 1'b0);                         wait_done();

        // randomized traffic; a zero gap issues start in the done cycle
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 5);
            s = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case (mode)
                1: begin
                    a = 64'($urandom_range(0, 5000)); if ($urandom_range(0, 1) == 1) a = -a;
                    b = 64'($urandom_range(1, 60));   if ($urandom_range(0, 1) == 1) b = -b;
                end
                2: b = 64'd0;
                3: begin a = c_MN; b = c_ONES; end
                4: b[63] = 1'b1;
                5: b = 64'($urandom_range(1, 1000));
                default: a = a;
            endcase
            issue(a, b, s);
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results still pending", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
